traffic_light_ctrl_param: RTL and testbench

//  Parametrised two-road traffic-light controller; successor of the fixed-timing controller.

---
 rtl/traffic_light_ctrl_param.sv | 201 ++++++++++++++++++++
 tb/tb_traffic_light_ctrl_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_ctrl_param
// Purpose  : Parametrised two-road traffic-light controller. It provides
//            per-phase durations, all-red clearance after each yellow,
//            optional road-2 demand actuation, a 1 Hz yellow-flash
//            maintenance mode, and countdown/state outputs for a display.
// Ports    : clk        system clock (CLK_HZ cycles per second)
//            reset      synchronous, active-high
//            maintain   level; 1 selects maintenance (flash) mode
//            req2       road-2 demand, sampled every cycle
//            red1/yellow1/green1, red2/yellow2/green2   lamp drives
//            state      current state encoding (0 G1 .. 5 R2, 6 MAINT)
//            sec_left   seconds remaining in the phase; 0 in maintenance
//            sec_pulse  one-cycle strobe at the end of each second
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl_param #(
    parameter int CLK_HZ   = 1024,
    parameter int GREEN1_S = 30,
    parameter int GREEN2_S = 20,
    parameter int YELLOW_S = 3,
    parameter int ALLRED_S = 1,
    parameter int ACTUATED = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             maintain,
    input  logic             req2,
    output logic             red1,
    output logic             yellow1,
    output logic             green1,
    output logic             red2,
    output logic             yellow2,
    output logic             green2,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] sec_left,
    output logic             sec_pulse
);

    localparam int                    c_PRESC_W    = $clog2(CLK_HZ);
    localparam logic [c_PRESC_W-1:0]  c_PRESC_MAX  = c_PRESC_W'(CLK_HZ - 1);
    localparam logic [c_PRESC_W-1:0]  c_PRESC_HALF = c_PRESC_W'(CLK_HZ / 2);
    localparam logic [CNT_W-1:0]      c_DUR_G1     = CNT_W'(GREEN1_S);
    localparam logic [CNT_W-1:0]      c_DUR_G2     = CNT_W'(GREEN2_S);
    localparam logic [CNT_W-1:0]      c_DUR_Y      = CNT_W'(YELLOW_S);
    localparam logic [CNT_W-1:0]      c_DUR_AR     = CNT_W'(ALLRED_S);
    localparam logic [CNT_W-1:0]      c_ONE        = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_G1    = 3'd0,
        ST_Y1    = 3'd1,
        ST_R1    = 3'd2,
        ST_G2    = 3'd3,
        ST_Y2    = 3'd4,
        ST_R2    = 3'd5,
        ST_MAINT = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_PRESC_W-1:0]  r_presc;
    logic [c_PRESC_W-1:0]  w_presc_nxt;
    logic [CNT_W-1:0]      r_sec_left;
    logic [CNT_W-1:0]      w_sec_nxt;
    logic                  r_req;
    logic                  w_req_nxt;
    logic                  w_pulse;
    logic                  w_g1_exit_ok;
    logic                  w_flash_on;

    assign w_pulse      = (r_presc == c_PRESC_MAX);
    // In fixed-cycle mode the demand latch plays no part in leaving G1.
    assign w_g1_exit_ok = (ACTUATED == 0) || r_req;
    assign w_flash_on   = (r_presc < c_PRESC_HALF);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_G1;
            r_sec_left <= c_DUR_G1;
            r_presc    <= '0;
            r_req      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sec_left <= w_sec_nxt;
            r_presc    <= w_presc_nxt;
            r_req      <= w_req_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sec_nxt   = r_sec_left;
        w_presc_nxt = w_pulse ? '0 : r_presc + 1'b1;
        w_req_nxt   = r_req;

        if (maintain) begin
            // Maintenance overrides any phase expiry in the same cycle.
            w_state_nxt = ST_MAINT;
            w_sec_nxt   = '0;
        end else if (r_state == ST_MAINT) begin
            // Leave maintenance through an all-red clearance before G1.
            w_state_nxt = ST_R2;
            w_sec_nxt   = c_DUR_AR;
        end else if (w_pulse) begin
            if (r_sec_left <= c_ONE) begin
                case (r_state)
                    ST_G1: begin
                        // Actuated G1 without demand holds at 1 s remaining.
                        if (w_g1_exit_ok) begin
                            w_state_nxt = ST_Y1;
                            w_sec_nxt   = c_DUR_Y;
                        end
                    end
                    ST_Y1: begin
                        w_state_nxt = ST_R1;
                        w_sec_nxt   = c_DUR_AR;
                    end
                    ST_R1: begin
                        w_state_nxt = ST_G2;
                        w_sec_nxt   = c_DUR_G2;
                    end
                    ST_G2: begin
                        w_state_nxt = ST_Y2;
                        w_sec_nxt   = c_DUR_Y;
                    end
                    ST_Y2: begin
                        w_state_nxt = ST_R2;
                        w_sec_nxt   = c_DUR_AR;
                    end
                    default: begin
                        w_state_nxt = ST_G1;
                        w_sec_nxt   = c_DUR_G1;
                    end
                endcase
            end else begin
                w_sec_nxt = r_sec_left - c_ONE;
            end
        end

        // Restart the second prescaler on every state change so each
        // phase lasts exactly its duration in whole seconds.
        if (w_state_nxt != r_state) begin
            w_presc_nxt = '0;
        end

        // Demand is cleared on entry to G2; while road 2 is being served
        // (G2/Y2) further requests are not recorded.
        if ((w_state_nxt == ST_G2) && (r_state != ST_G2)) begin
            w_req_nxt = 1'b0;
        end else if (req2 && (r_state != ST_G2) && (r_state != ST_Y2)) begin
            w_req_nxt = 1'b1;
        end
    end

    always_comb begin
        red1    = 1'b0;
        yellow1 = 1'b0;
        green1  = 1'b0;
        red2    = 1'b0;
        yellow2 = 1'b0;
        green2  = 1'b0;
        case (r_state)
            ST_G1: begin
                green1 = 1'b1;
                red2   = 1'b1;
            end
            ST_Y1: begin
                yellow1 = 1'b1;
                red2    = 1'b1;
            end
            ST_R1, ST_R2: begin
                red1 = 1'b1;
                red2 = 1'b1;
            end
            ST_G2: begin
                red1   = 1'b1;
                green2 = 1'b1;
            end
            ST_Y2: begin
                red1    = 1'b1;
                yellow2 = 1'b1;
            end
            ST_MAINT: begin
                yellow1 = w_flash_on;
                yellow2 = w_flash_on;
            end
            default: begin
                red1 = 1'b1;
                red2 = 1'b1;
            end
        endcase
    end

    assign state     = r_state;
    assign sec_left  = r_sec_left;
    assign sec_pulse = w_pulse;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_ctrl_param
// Purpose  : Directed self-checking bench for traffic_light_ctrl_param.
//            One fixed-cycle instance (a) and one actuated instance (b)
//            share clock and inputs; each step checks the instance it
//            targets against hand-derived expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl_param;

    localparam int c_CLK_HZ   = 4;
    localparam int c_GREEN1_S = 3;
    localparam int c_GREEN2_S = 2;
    localparam int c_YELLOW_S = 2;
    localparam int c_ALLRED_S = 1;
    localparam int c_CNT_W    = 4;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic maintain = 1'b0;
    logic req2     = 1'b0;

    logic             red1_a, yellow1_a, green1_a, red2_a, yellow2_a, green2_a;
    logic [2:0]       state_a;
    logic [c_CNT_W-1:0] sec_left_a;
    logic             sec_pulse_a;

    logic             red1_b, yellow1_b, green1_b, red2_b, yellow2_b, green2_b;
    logic [2:0]       state_b;
    logic [c_CNT_W-1:0] sec_left_b;
    logic             sec_pulse_b;

    traffic_light_ctrl_param #(
        .CLK_HZ(c_CLK_HZ), .GREEN1_S(c_GREEN1_S), .GREEN2_S(c_GREEN2_S),
        .YELLOW_S(c_YELLOW_S), .ALLRED_S(c_ALLRED_S), .ACTUATED(0), .CNT_W(c_CNT_W)
    ) dut_a (
        .clk(clk), .reset(reset), .maintain(maintain), .req2(req2),
        .red1(red1_a), .yellow1(yellow1_a), .green1(green1_a),
        .red2(red2_a), .yellow2(yellow2_a), .green2(green2_a),
        .state(state_a), .sec_left(sec_left_a), .sec_pulse(sec_pulse_a)
    );

    traffic_light_ctrl_param #(
        .CLK_HZ(c_CLK_HZ), .GREEN1_S(c_GREEN1_S), .GREEN2_S(c_GREEN2_S),
        .YELLOW_S(c_YELLOW_S), .ALLRED_S(c_ALLRED_S), .ACTUATED(1), .CNT_W(c_CNT_W)
    ) dut_b (
        .clk(clk), .reset(reset), .maintain(maintain), .req2(req2),
        .red1(red1_b), .yellow1(yellow1_b), .green1(green1_b),
        .red2(red2_b), .yellow2(yellow2_b), .green2(green2_b),
        .state(state_b), .sec_left(sec_left_b), .sec_pulse(sec_pulse_b)
    );

    wire [5:0] lamps_a = {red1_a, yellow1_a, green1_a, red2_a, yellow2_a, green2_a};
    wire [5:0] lamps_b = {red1_b, yellow1_b, green1_b, red2_b, yellow2_b, green2_b};

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Leaves the bench in cycle 0: the first cycle after reset is released.
    task automatic do_reset();
        reset    = 1'b1;
        maintain = 1'b0;
        req2     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Fixed-cycle state timeline after reset release at cycle 0.
    function automatic int exp_seq(input int n);
        if (n < 12)      return 0;
        else if (n < 20) return 1;
        else if (n < 24) return 2;
        else if (n < 32) return 3;
        else if (n < 40) return 4;
        else if (n < 44) return 5;
        else             return 0;
    endfunction

    // {red1,yellow1,green1,red2,yellow2,green2} for each normal state.
    function automatic logic [5:0] exp_lamps(input int st);
        case (st)
            0:       return 6'b001_100;
            1:       return 6'b010_100;
            2:       return 6'b100_100;
            3:       return 6'b100_001;
            4:       return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        chk("rst_state",  32'(state_a), 0);
        chk("rst_sec",    32'(sec_left_a), 3);
        chk("rst_pulse",  32'(sec_pulse_a), 0);
        chk("rst_lamps",  32'(lamps_a), 32'(6'b001_100));
        chk("rst_latch",  32'(dut_a.r_req), 0);

        // ---------------- 1: fixed cycle timeline ----------------
        for (int n = 0; n < 48; n++) begin
            chk("t1_state", 32'(state_a), 32'(exp_seq(n)));
            chk("t1_lamps", 32'(lamps_a), 32'(exp_lamps(exp_seq(n))));
            chk("t1_pulse", 32'(sec_pulse_a), 32'((n % 4) == 3));
            if (n < 12) chk("t1_g1_sec", 32'(sec_left_a), 32'(3 - n / 4));
            tick();
        end

        // ---------------- 2: actuated, no demand ----------------
        do_reset();
        for (int n = 0; n < 100; n++) begin
            chk("t2_hold_state", 32'(state_b), 0);
            if (n >= 8) chk("t2_hold_sec", 32'(sec_left_b), 1);
            tick();
        end

        // ---------------- 2b: actuated, demand pulse at cycle 50 ----------------
        do_reset();
        run_to(50);
        chk("t2b_pre_state", 32'(state_b), 0);
        req2 = 1'b1;
        tick();                     // cycle 51
        req2 = 1'b0;
        chk("t2b_51_state", 32'(state_b), 0);
        chk("t2b_51_latch", 32'(dut_b.r_req), 1);
        chk("t2b_51_pulse", 32'(sec_pulse_b), 1);
        tick();                     // cycle 52
        chk("t2b_52_state", 32'(state_b), 1);
        chk("t2b_52_sec",   32'(sec_left_b), 2);
        chk("t2b_52_latch", 32'(dut_b.r_req), 1);

        // ---------------- 3: maintenance during G2 ----------------
        do_reset();
        run_to(25);
        chk("t3_in_g2", 32'(state_a), 3);
        maintain = 1'b1;
        tick();                     // cycle 26
        for (int k = 0; k < 8; k++) begin
            chk("t3_m_state", 32'(state_a), 6);
            chk("t3_m_sec",   32'(sec_left_a), 0);
            chk("t3_m_lamps", 32'(lamps_a),
                ((k % 4) < 2) ? 32'(6'b010_010) : 32'(6'b000_000));
            if (k == 7) maintain = 1'b0;
            tick();
        end
        for (int k = 0; k < 4; k++) begin   // cycles 34..37
            chk("t3_r2_state", 32'(state_a), 5);
            chk("t3_r2_lamps", 32'(lamps_a), 32'(6'b100_100));
            chk("t3_r2_sec",   32'(sec_left_a), 1);
            tick();
        end
        chk("t3_back_g1",     32'(state_a), 0);
        chk("t3_back_g1_sec", 32'(sec_left_a), 3);

        // ---------------- 4: reset mid-Y1 ----------------
        do_reset();
        run_to(5);
        req2 = 1'b1;
        run_to(15);
        req2 = 1'b0;
        chk("t4_y1_state", 32'(state_a), 1);
        chk("t4_y1_sec",   32'(sec_left_a), 2);
        chk("t4_y1_latch", 32'(dut_a.r_req), 1);
        reset = 1'b1;
        tick();
        chk("t4_rst_state", 32'(state_a), 0);
        chk("t4_rst_sec",   32'(sec_left_a), 3);
        chk("t4_rst_lamps", 32'(lamps_a), 32'(6'b001_100));
        chk("t4_rst_pulse", 32'(sec_pulse_a), 0);
        chk("t4_rst_latch", 32'(dut_a.r_req), 0);
        reset = 1'b0;

        // ---------------- 5: latch window, maintain vs Y2 expiry ----------------
        do_reset();
        run_to(20);
        req2 = 1'b1;
        run_to(23);
        chk("t5_r1_latch",  32'(dut_a.r_req), 1);
        tick();                     // cycle 24, G2 entry; req2 still high
        chk("t5_g2_state",  32'(state_a), 3);
        chk("t5_g2_latch",  32'(dut_a.r_req), 0);
        run_to(39);
        chk("t5_y2_state",  32'(state_a), 4);
        chk("t5_y2_sec",    32'(sec_left_a), 1);
        chk("t5_y2_pulse",  32'(sec_pulse_a), 1);
        chk("t5_y2_latch",  32'(dut_a.r_req), 0);
        req2     = 1'b0;
        maintain = 1'b1;
        tick();                     // cycle 40
        chk("t5_maint_state", 32'(state_a), 6);
        chk("t5_maint_sec",   32'(sec_left_a), 0);
        maintain = 1'b0;
        tick();                     // cycle 41
        chk("t5_exit_state",  32'(state_a), 5);
        chk("t5_exit_sec",    32'(sec_left_a), 1);

        // ---------------- 6: random maintain/req2 invariants ----------------
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(15) == 0) maintain = ~maintain;
            req2 = ($urandom_range(3) == 0);
            tick();
            chk("t6_no_gg_a", 32'(green1_a & green2_a), 0);
            chk("t6_no_gg_b", 32'(green1_b & green2_b), 0);
            chk("t6_sec_a",   32'(sec_left_a <= 4'd3), 1);
            chk("t6_sec_b",   32'(sec_left_b <= 4'd3), 1);
            if (state_a != 3'd6) begin
                chk("t6_road1_a", 32'($countones({red1_a, yellow1_a, green1_a})), 1);
                chk("t6_road2_a", 32'($countones({red2_a, yellow2_a, green2_a})), 1);
            end else begin
                chk("t6_maint_rg_a", 32'({red1_a, green1_a, red2_a, green2_a}), 0);
            end
            if (state_b != 3'd6) begin
                chk("t6_road1_b", 32'($countones({red1_b, yellow1_b, green1_b})), 1);
                chk("t6_road2_b", 32'($countones({red2_b, yellow2_b, green2_b})), 1);
            end else begin
                chk("t6_maint_rg_b", 32'({red1_b, green1_b, red2_b, green2_b}), 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
